// File: rtl/booth_mult.sv
// Sequential radix-4 Booth signed multiplier.
// Retires one Booth digit per clock; P updates only on completion.
module booth_mult #(
    parameter int A_WIDTH = 24,
    parameter int B_WIDTH = 8,
    parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic [P_WIDTH-1:0] P
);

    localparam int DIGITS = B_WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS) + 1;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [P_WIDTH-1:0] r_m;
    logic [B_WIDTH:0]   r_br;
    logic [P_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [P_WIDTH-1:0] r_p;

    logic               w_last;
    logic               w_start;
    logic               w_step;
    logic               w_done;
    logic [2:0]         w_trip;
    logic [P_WIDTH-1:0] w_term;
    logic [CNT_W:0]     w_shamt;
    logic [P_WIDTH-1:0] w_sum;

    assign w_last = (r_cnt == CNT_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (load) w_next = S_BUSY;
            end
            S_BUSY: begin
                if (load)        w_next = S_BUSY;
                else if (w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A load always wins over an in-flight iteration.
    always_comb begin
        w_start = load;
        w_step  = (r_state == S_BUSY) && !load;
        w_done  = w_step && w_last;
    end

    assign w_trip = r_br[2:0];

    always_comb begin
        w_term = '0;
        unique case (w_trip)
            3'b000, 3'b111: w_term = '0;
            3'b001, 3'b010: w_term = r_m;
            3'b011:         w_term = r_m << 1;
            3'b100:         w_term = -(r_m << 1);
            default:        w_term = -r_m;
        endcase
    end

    assign w_shamt = {r_cnt, 1'b0};
    assign w_sum   = r_acc + (w_term << w_shamt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m   <= '0;
            r_br  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_p   <= '0;
        end else if (w_start) begin
            r_m   <= {{B_WIDTH{A[A_WIDTH-1]}}, A};
            r_br  <= {B, 1'b0};
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_step) begin
            r_acc <= w_sum;
            r_br  <= r_br >> 2;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_done) r_p <= w_sum;
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult against a plain
// signed-multiply reference model.
module tb_booth_mult;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [23:0] A;
    logic [7:0]  B;
    logic [31:0] P;

    int          n_checks;
    int          n_fails;
    logic [31:0] exp_p;

    booth_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .A     (A),
        .B     (B),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [23:0] a,
                                            input logic [7:0] b);
        longint prod;
        prod = longint'($signed(a)) * longint'($signed(b));
        return prod[31:0];
    endfunction

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input logic [23:0] a, input logic [7:0] b);
        load = 1'b1;
        A    = a;
        B    = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Load, check P holds for 3 edges, then equals the product.
    task automatic run_op(input logic [23:0] a, input logic [7:0] b,
                          input string tag);
        logic [31:0] want;
        want = ref_mul(a, b);
        do_load(a, b);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (P !== exp_p) begin
                n_fails++;
                $display("FAIL %s early: P=%h expected held %h", tag, P, exp_p);
            end
        end
        @(negedge clk);
        n_checks++;
        if (P !== want) begin
            n_fails++;
            $display("FAIL %s: A=%h B=%h P=%h expected %h", tag, a, b, P, want);
        end
        exp_p = want;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        load  = 1'b0;
        A     = '0;
        B     = '0;
        exp_p = '0;
        #12;
        n_checks++;
        if (P !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_state: P=%h expected 00000000", P);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_op(24'd15, 8'd9, "basic_15x9");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (P !== 32'h00000087) begin
                n_fails++;
                $display("FAIL hold cycle %0d: P=%h expected 00000087", i, P);
            end
        end
    endtask

    task automatic test_corners;
        run_op(24'hFFFFFF, 8'h80, "neg1_x_min");
        if (exp_p !== 32'h00000080) begin
            n_fails++;
            $display("FAIL model neg1_x_min: %h expected 00000080", exp_p);
        end
        run_op(24'h800000, 8'h80, "min_x_min");
        run_op(24'h7FFFFF, 8'h7F, "max_x_max");
        run_op(24'h000000, 8'h5A, "zero_a");
        run_op(24'h123456, 8'h00, "zero_b");
        run_op(24'h800000, 8'h7F, "min_x_max");
        run_op(24'h7FFFFF, 8'h80, "max_x_min");
    endtask

    task automatic test_random;
        logic [23:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 25; i++) begin
            a = 24'($urandom_range(2000, 1));
            b = 8'($urandom_range(128, 1));
            run_op(a, b, "rand_small");
        end
        for (int i = 0; i < 30; i++) begin
            a = 24'($urandom);
            b = 8'($urandom);
            run_op(a, b, "rand_full");
        end
    endtask

    task automatic test_restart;
        logic [31:0] old_p;
        old_p = exp_p;
        do_load(24'd100, 8'd3);
        @(negedge clk);
        do_load(24'd7, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (P === 32'd300) begin
                n_fails++;
                $display("FAIL restart_leak: P=%h must never be 0000012c", P);
            end
            if (i < 3) begin
                n_checks++;
                if (P !== old_p) begin
                    n_fails++;
                    $display("FAIL restart_hold: P=%h expected %h", P, old_p);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (P !== 32'hFFFFFFF2) begin
            n_fails++;
            $display("FAIL restart: P=%h expected fffffff2", P);
        end
        exp_p = 32'hFFFFFFF2;
    endtask

    task automatic test_load_held;
        load = 1'b1;
        A = 24'd11; B = 8'd13;
        @(negedge clk);
        A = 24'd21; B = 8'd5;
        @(negedge clk);
        run_op(24'hFFF000, 8'd37, "load_held");
    endtask

    task automatic test_back_to_back;
        run_op(24'd1234, 8'd100, "b2b_0");
        run_op(24'hABCDEF, 8'hC3, "b2b_1");
        run_op(24'd3, 8'd3, "b2b_2");
    endtask

    task automatic test_async_reset;
        do_load(24'd555, 8'd77);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (P !== 32'h0) begin
            n_fails++;
            $display("FAIL async_reset: P=%h expected 00000000", P);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (P !== 32'h0) begin
                n_fails++;
                $display("FAIL post_reset cycle %0d: P=%h expected 0", i, P);
            end
        end
        exp_p = '0;
        run_op(24'hFFFFFD, 8'd50, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_basic();
        test_corners();
        test_random();
        test_restart();
        test_load_held();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
